rst_seq_clken: RTL and testbench

Parametrised reset sequencer and clock-enable generator, placed directly after the PLL clock generator in the FPGA top level. It synchronises the PLL lock indication into the system clock domain and holds off reset for a fixed time after lock. It then releases per-subsystem resets one after another at fixed intervals. For each released channel it generates a divided clock-enable strobe, so slower peripherals run from the single system clock without extra PLL outputs.

---
 rtl/rst_seq_pkg.sv | 35 +++
 rtl/rst_seq_clkdiv.sv | 61 ++++++
 rtl/rst_seq_clken.sv | 180 ++++++++++++++++++
 tb/tb_rst_seq_clken.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared types and helpers for the reset sequencer / clock-enable generator.
//   - state_e        : sequencer FSM states
//   - hold_cnt_width : width of the post-lock hold counter
//   - stag_cnt_width : width of the channel-release stagger counter
//   - div_last       : terminal count of a divider (ratio 0 behaves as 1)
// ---------------------------------------------------------------------------
package rst_seq_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Bits needed to count 0..hold_cycles.
  function automatic int unsigned hold_cnt_width(input int unsigned hold_cycles);
    return 32'($clog2(hold_cycles + 32'd1));
  endfunction

  // Bits needed to count 0..num_channels*stagger_cycles.
  function automatic int unsigned stag_cnt_width(input int unsigned num_channels,
                                                 input int unsigned stagger_cycles);
    return 32'($clog2(num_channels * stagger_cycles + 32'd1));
  endfunction

  // Last counter value of a divide-by-ratio counter; ratio 0 is treated as 1.
  function automatic int unsigned div_last(input int unsigned ratio);
    return (ratio == 32'd0) ? 32'd0 : ratio - 32'd1;
  endfunction

endpackage : rst_seq_pkg

// File: rtl/rst_seq_clkdiv.sv
// ---------------------------------------------------------------------------
// rst_seq_clkdiv
// One channel's clock-enable divider. While en is low the counter is held at
// zero; once enabled it counts 0..ratio-1 and wraps. stb is high in the cycle
// the counter sits at ratio-1, so ratio 1 (or 0) gives a constant strobe.
//
// Ports
//   clk    in   1         system clock
//   rst_n  in   1         synchronous active-low reset
//   en     in   1         channel released (next-cycle value of the release)
//   ratio  in   DivWidth  divide ratio
//   stb    out  1         registered clock-enable strobe
// ---------------------------------------------------------------------------
module rst_seq_clkdiv
  import rst_seq_pkg::*;
#(
  parameter int unsigned DivWidth = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [DivWidth-1:0] ratio,
  output logic                stb
);

  logic [DivWidth-1:0] last_c;
  logic [DivWidth-1:0] cnt_q;
  logic [DivWidth-1:0] cnt_d;
  logic                active_q;
  logic                stb_d;

  assign last_c = DivWidth'(div_last(32'(ratio)));

  // en is the release value for the coming cycle, so the strobe register
  // lines up with the released reset output without an extra cycle of lag.
  always_comb begin
    cnt_d = '0;
    stb_d = 1'b0;
    if (en) begin
      // First released cycle starts at zero; afterwards count and wrap.
      if (active_q && (cnt_q < last_c)) begin
        cnt_d = cnt_q + DivWidth'(1);
      end
      stb_d = (cnt_d == last_c);
    end
  end

  // Counter, enable history and strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      stb      <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= en;
      stb      <= stb_d;
    end
  end

endmodule : rst_seq_clkdiv

// File: rtl/rst_seq_clken.sv
// ---------------------------------------------------------------------------
// rst_seq_clken
// Reset sequencer and clock-enable generator sitting behind the PLL. The PLL
// lock is synchronised into clk_i, reset is held for HoldCycles after lock,
// then per-channel resets are released every StaggerCycles. Each released
// channel gets a divided clock-enable strobe.
//
// Optional feature macro: RST_SEQ_LOCK_LOSS_RESET_EN
//   defined   : lock loss in RUN also drops every output and restarts the
//               sequence on relock
//   undefined : lock loss in RUN only raises the sticky lock_lost_o
//
// Ports
//   clk_i        in   1            system clock
//   rst_ni       in   1            synchronous active-low reset
//   locked_i     in   1            PLL lock, asynchronous to clk_i
//   rst_no       out  NumChannels  per-channel reset, active-low
//   clk_en_o     out  NumChannels  per-channel clock-enable strobe
//   ready_o      out  1            all channels released
//   lock_lost_o  out  1            sticky: lock dropped while in RUN
// ---------------------------------------------------------------------------
module rst_seq_clken
  import rst_seq_pkg::*;
#(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned HoldCycles    = 16,
  parameter int unsigned StaggerCycles = 4,
  parameter int unsigned DivWidth      = 8,
  parameter logic [NumChannels-1:0][DivWidth-1:0] DivRatios = {8'd8, 8'd4, 8'd2, 8'd1}
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   locked_i,
  output logic [NumChannels-1:0] rst_no,
  output logic [NumChannels-1:0] clk_en_o,
  output logic                   ready_o,
  output logic                   lock_lost_o
);

  localparam int unsigned HoldW       = hold_cnt_width(HoldCycles);
  localparam int unsigned StagW       = stag_cnt_width(NumChannels, StaggerCycles);
  localparam int unsigned LastRelease = (NumChannels - 1) * StaggerCycles;

  logic [SyncStages-1:0]  sync_q;
  logic                   lock_sync;

  state_e                 state_q;
  state_e                 state_d;
  logic [HoldW-1:0]       hold_q;
  logic [HoldW-1:0]       hold_d;
  logic [StagW-1:0]       stag_q;
  logic [StagW-1:0]       stag_d;
  logic [NumChannels-1:0] rel_q;
  logic [NumChannels-1:0] rel_d;
  logic [NumChannels-1:0] rel_hit_c;
  logic                   ready_q;
  logic                   ready_d;
  logic                   lost_q;
  logic                   lost_d;

  // Lock synchroniser: plain flop chain, the last stage is the safe copy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], locked_i};
    end
  end

  assign lock_sync = sync_q[SyncStages-1];

  // Channel i is due when the stagger count reaches i*StaggerCycles.
  for (genvar g = 0; g < NumChannels; g++) begin : g_hit
    assign rel_hit_c[g] = (stag_q == StagW'(g * StaggerCycles));
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= WAIT_LOCK;
      hold_q  <= '0;
      stag_q  <= '0;
      rel_q   <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    rel_d   = rel_q;
    ready_d = 1'b0;
    lost_d  = lost_q;

    unique case (state_q)
      WAIT_LOCK: begin
        rel_d = '0;
        if (lock_sync) begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end

      HOLD: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          rel_d   = '0;
        end else if (hold_q == HoldW'(HoldCycles - 1)) begin
          state_d = RELEASE;
          stag_d  = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end

      RELEASE: begin
        if (!lock_sync) begin
          state_d = WAIT_LOCK;
          rel_d   = '0;
        end else begin
          // Releases accumulate; a released channel never re-enters reset here.
          rel_d  = rel_q | rel_hit_c;
          stag_d = stag_q + StagW'(1);
          if (stag_q == StagW'(LastRelease)) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        ready_d = 1'b1;
        if (!lock_sync) begin
          lost_d = 1'b1;
`ifdef RST_SEQ_LOCK_LOSS_RESET_EN
          state_d = WAIT_LOCK;
          rel_d   = '0;
          ready_d = 1'b0;
`else
          state_d = RUN;
`endif
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        rel_d   = '0;
      end
    endcase
  end

  // Per-channel dividers run off the next release value so the strobe
  // register is aligned with the rst_no register.
  for (genvar g = 0; g < NumChannels; g++) begin : g_div
    rst_seq_clkdiv #(
      .DivWidth (DivWidth)
    ) u_clkdiv (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .en    (rel_d[g]),
      .ratio (DivRatios[g]),
      .stb   (clk_en_o[g])
    );
  end

  assign rst_no      = rel_q;
  assign ready_o     = ready_q;
  assign lock_lost_o = lost_q;

endmodule : rst_seq_clken

// File: tb/tb_rst_seq_clken.sv
// ---------------------------------------------------------------------------
// tb_rst_seq_clken
// Directed bench for rst_seq_clken with default parameters. The stimulus
// process pushes per-cycle expected outputs into a scoreboard queue; the
// monitor compares them on the falling edge of the cycle they belong to.
// ---------------------------------------------------------------------------
module tb_rst_seq_clken;

  typedef struct {
    int        cyc;
    logic [3:0] rst;
    logic [3:0] ce;
    logic       rdy;
    logic       lost;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic [3:0] rst_no;
  logic [3:0] clk_en;
  logic       ready;
  logic       lock_lost;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  rst_seq_clken dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .locked_i    (locked),
    .rst_no      (rst_no),
    .clk_en_o    (clk_en),
    .ready_o     (ready),
    .lock_lost_o (lock_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs k cycles after E0 (first edge sampling locked high):
  // channel i released at k = 19 + 4*i, ratios {1,2,4,8} for channels 0..3,
  // first strobe ratio-1 cycles after release, ready one cycle after ch3.
  function automatic exp_t seq_exp(input int c, input int k, input logic lost,
                                   input string tag);
    int   ratio[4];
    exp_t e;
    ratio[0] = 1; ratio[1] = 2; ratio[2] = 4; ratio[3] = 8;
    e.cyc  = c;
    e.rst  = 4'b0000;
    e.ce   = 4'b0000;
    e.rdy  = (k >= 32);
    e.lost = lost;
    e.tag  = tag;
    for (int i = 0; i < 4; i++) begin
      int rel_at;
      rel_at = 19 + 4 * i;
      if (k >= rel_at) begin
        e.rst[i] = 1'b1;
        if (((k - rel_at) % ratio[i]) == ratio[i] - 1) e.ce[i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic push_seq(input int base, input int k0, input int k1,
                          input logic lost, input string tag);
    for (int k = k0; k <= k1; k++) sb.push_back(seq_exp(base + k, k, lost, tag));
  endtask

  task automatic push_zero(input int c0, input int c1, input logic lost,
                           input string tag);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc = c; e.rst = 4'b0000; e.ce = 4'b0000; e.rdy = 1'b0;
      e.lost = lost; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every entry due at or before the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || rst_no !== e.rst || clk_en !== e.ce ||
          ready !== e.rdy || lock_lost !== e.lost) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d got rst_no=%b clk_en=%b ready=%b lost=%b exp rst_no=%b clk_en=%b ready=%b lost=%b",
                 e.tag, cyc, e.cyc, rst_no, clk_en, ready, lock_lost,
                 e.rst, e.ce, e.rdy, e.lost);
      end
    end
  end

  initial begin
    int e0, d, p, e2, e3, e4, guard;
    rst_n  = 1'b0;
    locked = 1'b0;

    // Reset state, then idle with no lock.
    wait_until(1);
    push_zero(2, 2, 1'b0, "reset");
    wait_until(2);
    rst_n = 1'b1;
    push_zero(3, 6, 1'b0, "idle");

    // Full release sequence and divider strobes.
    wait_until(6);
    locked = 1'b1;
    e0 = 7;
    push_seq(e0, 0, 45, 1'b0, "seq");

    // Lock drop while in RUN.
    wait_until(e0 + 45);
    locked = 1'b0;
    d = e0 + 46;
    push_seq(e0, d - e0, d - e0 + 1, 1'b0, "pre_drop");
`ifdef RST_SEQ_LOCK_LOSS_RESET_EN
    begin
      int e1;
      push_zero(d + 2, d + 10, 1'b1, "drop_run");
      wait_until(d + 10);
      locked = 1'b1;
      e1 = d + 11;
      push_seq(e1, 0, 35, 1'b1, "relock");
      wait_until(e1 + 35);
    end
`else
    push_seq(e0, d + 2 - e0, d + 20 - e0, 1'b1, "drop_run");
    wait_until(d + 10);
    locked = 1'b1;
    wait_until(d + 20);
`endif

    // Reset clears the sticky flag; then lock drop during HOLD.
    p = cyc;
    rst_n  = 1'b0;
    locked = 1'b0;
    push_zero(p + 1, p + 1, 1'b0, "rst_clr");
    wait_until(p + 1);
    rst_n = 1'b1;
    push_zero(p + 2, p + 3, 1'b0, "idle2");
    wait_until(p + 3);
    locked = 1'b1;
    e2 = p + 4;
    push_zero(e2, e2 + 25, 1'b0, "hold_drop");
    wait_until(e2 + 9);
    locked = 1'b0;
    wait_until(e2 + 25);
    locked = 1'b1;
    e3 = e2 + 26;
    push_seq(e3, 0, 25, 1'b0, "relock2");

    // One-cycle reset mid-sequence with lock still high.
    wait_until(e3 + 25);
    rst_n = 1'b0;
    push_zero(e3 + 26, e3 + 26, 1'b0, "mid_rst");
    wait_until(e3 + 26);
    rst_n = 1'b1;
    e4 = e3 + 27;
    push_seq(e4, 0, 35, 1'b0, "restart");
    wait_until(e4 + 35);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rst_seq_clken
